ahb_arb: RTL

Two-master to one-slave arbiter for the core's simplified AHB-lite bus (single-bit htrans, single-bit hresp). Master 0 is the instruction-fetch interface and master 1 is the data bus interface. The block arbitrates address phases, locks the grant while the slave stalls, and tracks which master owns the pending data phase. It routes hwdata to the slave and routes hrdata/hready/hresp back to the correct master. It sits between the core bus interfaces and the system interconnect.

---
 rtl/femto_bus_pkg.sv | 20 ++
 rtl/ahb_arb_pick.sv | 34 +++
 rtl/ahb_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/femto_bus_pkg.sv
// Shared bus types for the simplified AHB-lite fabric.
package femto_bus_pkg;

   // Owner of the pending data phase
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_t;

   localparam logic [1:0] HSIZE_BYTE = 2'b00;
   localparam logic [1:0] HSIZE_HALF = 2'b01;
   localparam logic [1:0] HSIZE_WORD = 2'b10;

   // Map a master index to its data-phase owner code
   function automatic owner_t owner_of(input logic m);
      return m ? OWN_M1 : OWN_M0;
   endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Two-way address-phase picker for ahb_arb.
// Policy: fixed priority (master 1 wins) by default; round-robin when
// AHB_ARB_RR_EN is defined.
module ahb_arb_pick (
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       lock_i,
   input  logic       gnt_q_i,
   output logic       gnt_o
);

`ifndef AHB_ARB_RR_EN
   logic unused_last;
   assign unused_last = last_i;
`endif

   // Hold the grant while locked or idle, otherwise pick among requesters
   always_comb begin
      gnt_o = gnt_q_i;
      if (!lock_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
`ifdef AHB_ARB_RR_EN
            2'b11:   gnt_o = ~last_i;
`else
            2'b11:   gnt_o = 1'b1;
`endif
            default: gnt_o = gnt_q_i;
         endcase
      end
   end

endmodule

// File: rtl/ahb_arb.sv
// Two-master to one-slave arbiter for the simplified AHB-lite bus.
// Master 0 = instruction fetch, master 1 = data.
// Optional macro AHB_ARB_RR_EN selects round-robin arbitration.
module ahb_arb
   import femto_bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_htrans,
   input  logic [AW-1:0] m0_haddr,
   input  logic          m0_hwrite,
   input  logic [1:0]    m0_hsize,
   input  logic          m0_hprot,
   input  logic [DW-1:0] m0_hwdata,
   output logic [DW-1:0] m0_hrdata,
   output logic          m0_hready,
   output logic          m0_hresp,
   input  logic          m1_htrans,
   input  logic [AW-1:0] m1_haddr,
   input  logic          m1_hwrite,
   input  logic [1:0]    m1_hsize,
   input  logic          m1_hprot,
   input  logic [DW-1:0] m1_hwdata,
   output logic [DW-1:0] m1_hrdata,
   output logic          m1_hready,
   output logic          m1_hresp,
   output logic          s_htrans,
   output logic [AW-1:0] s_haddr,
   output logic          s_hwrite,
   output logic [1:0]    s_hsize,
   output logic          s_hprot,
   output logic [DW-1:0] s_hwdata,
   input  logic [DW-1:0] s_hrdata,
   input  logic          s_hready,
   input  logic          s_hresp
);

   logic   gnt_q, gnt_d;
   logic   last_q, last_d;
   owner_t dp_own_q, dp_own_d;
   logic   gnt;
   logic   htrans_sel;

   ahb_arb_pick u_pick (
      .req_i   ({m1_htrans, m0_htrans}),
      .last_i  (last_q),
      .lock_i  (~s_hready),
      .gnt_q_i (gnt_q),
      .gnt_o   (gnt)
   );

   // Address-phase mux from the granted master
   always_comb begin
      htrans_sel = gnt ? m1_htrans : m0_htrans;
      s_htrans   = htrans_sel & ~rst;
      s_haddr    = gnt ? m1_haddr  : m0_haddr;
      s_hwrite   = gnt ? m1_hwrite : m0_hwrite;
      s_hsize    = gnt ? m1_hsize  : m0_hsize;
      s_hprot    = gnt ? m1_hprot  : m0_hprot;
   end

   // Next-state: grant register, data-phase owner and last winner
   always_comb begin
      gnt_d    = gnt;
      dp_own_d = dp_own_q;
      last_d   = last_q;
      if (s_hready) begin
         dp_own_d = htrans_sel ? owner_of(gnt) : OWN_NONE;
         if (htrans_sel) last_d = gnt;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q    <= 1'b0;
         dp_own_q <= OWN_NONE;
         last_q   <= 1'b0;
      end else begin
         gnt_q    <= gnt_d;
         dp_own_q <= dp_own_d;
         last_q   <= last_d;
      end
   end

   // Data-phase routing and per-master handshake
   always_comb begin
      unique case (dp_own_q)
         OWN_M0:  s_hwdata = m0_hwdata;
         OWN_M1:  s_hwdata = m1_hwdata;
         default: s_hwdata = '0;
      endcase

      m0_hrdata = s_hrdata;
      m1_hrdata = s_hrdata;

      if (dp_own_q == OWN_M0 || (!gnt && m0_htrans)) m0_hready = s_hready;
      else                                            m0_hready = ~m0_htrans;
      if (dp_own_q == OWN_M1 || (gnt && m1_htrans))  m1_hready = s_hready;
      else                                            m1_hready = ~m1_htrans;

      m0_hresp = (dp_own_q == OWN_M0) ? s_hresp : 1'b0;
      m1_hresp = (dp_own_q == OWN_M1) ? s_hresp : 1'b0;

      if (rst) begin
         m0_hready = 1'b1;
         m1_hready = 1'b1;
         m0_hresp  = 1'b0;
         m1_hresp  = 1'b0;
      end
   end

endmodule
